// File: rtl/io_bus_arbiter_pkg.sv
// Shared types for the IO bus block: channel/master counts, arbiter FSM
// state encoding and the round-robin pointer advance helper.
package io_bus_arbiter_pkg;

    localparam int NOS_PWM_CHANNELS   = 4;
    localparam int DEF_NOS_MASTERS    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // Ownership counter width is fixed so the timeout range is the same for every build.
    localparam int CNT_W = 16;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_OWNED = 2'd1;
    localparam arb_state_t ST_GAP   = 2'd2;

    function automatic int rr_next(input int owner, input int nos_masters);
        return (owner == nos_masters - 1) ? 0 : owner + 1;
    endfunction

endpackage

// File: rtl/io_bus_arbiter_rr_priority_select.sv
// Combinational round-robin pick: first requester at or after ptr (wrapping)
// wins; winner is one-hot and valid flags that any request was present.
module rr_priority_select #(
    parameter int NOS_MASTERS = 2
) (
    input  logic [NOS_MASTERS-1:0]         req,
    input  logic [$clog2(NOS_MASTERS)-1:0] ptr,
    output logic [NOS_MASTERS-1:0]         winner,
    output logic                           valid
);

    int idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NOS_MASTERS; i++) begin
            idx = (int'(ptr) + i) % NOS_MASTERS;
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// IO bus arbiter: round-robin ownership with registered one-hot grant,
// one-cycle turnaround gap and a sticky forced-release (timeout) flag.
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int NOS_MASTERS    = DEF_NOS_MASTERS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NOS_MASTERS-1:0]         req,
    // 'release' is a reserved word, hence the longer name.
    input  logic [NOS_MASTERS-1:0]         release_pulse,
    input  logic                           clear_err,
    output logic [NOS_MASTERS-1:0]         grant,
    output logic [$clog2(NOS_MASTERS)-1:0] grant_id,
    output logic                           bus_busy,
    output logic                           timeout_flag
);

    localparam int IDW = $clog2(NOS_MASTERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t             state;
    logic [IDW-1:0]         ptr;
    logic [IDW-1:0]         win_id;
    logic [NOS_MASTERS-1:0] win_oh;
    logic                   win_vld;
    logic [CNT_W-1:0]       own_cnt;
    logic                   owner_rel;
    logic                   timeout_hit;

    rr_priority_select #(
        .NOS_MASTERS (NOS_MASTERS)
    ) u_rr_sel (
        .req    (req),
        .ptr    (ptr),
        .winner (win_oh),
        .valid  (win_vld)
    );

    always_comb begin
        win_id = '0;
        for (int i = 0; i < NOS_MASTERS; i++) begin
            if (win_oh[i]) win_id = IDW'(i);
        end
    end

    // grant_id holds the owner while OWNED, so it doubles as the owner index.
    assign owner_rel   = (state == ST_OWNED) && release_pulse[grant_id];
    assign timeout_hit = (state == ST_OWNED) && !owner_rel && (own_cnt == CNT_LAST);
    assign bus_busy    = |grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant    <= '0;
            grant_id <= '0;
            own_cnt  <= '0;
            ptr      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        grant    <= win_oh;
                        grant_id <= win_id;
                        own_cnt  <= '0;
                        state    <= ST_OWNED;
                    end
                end
                ST_OWNED: begin
                    if (owner_rel || timeout_hit) begin
                        grant    <= '0;
                        grant_id <= '0;
                        ptr      <= IDW'(rr_next(int'(grant_id), NOS_MASTERS));
                        state    <= ST_GAP;
                    end else if (own_cnt != '1) begin
                        own_cnt <= own_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    grant    <= '0;
                    grant_id <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Set wins over clear when both land in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_flag <= 1'b0;
        end else if (timeout_hit) begin
            timeout_flag <= 1'b1;
        end else if (clear_err) begin
            timeout_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scenario bench for io_bus_arbiter (2 masters, timeout of 8 owned cycles):
// per-cycle expectations are queued as stimulus is applied and compared after each edge.
module tb_io_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear_err;
    logic [1:0] req;
    logic [1:0] release_pulse;
    logic [1:0] grant;
    logic [0:0] grant_id;
    logic       bus_busy;
    logic       timeout_flag;

    io_bus_arbiter #(
        .NOS_MASTERS    (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .release_pulse (release_pulse),
        .clear_err     (clear_err),
        .grant         (grant),
        .grant_id      (grant_id),
        .bus_busy      (bus_busy),
        .timeout_flag  (timeout_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] grant;
        logic       id;
        logic       busy;
        logic       flag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic exp_t mk(input logic [1:0] g, input logic f);
        exp_t e;
        e.grant = g;
        e.id    = (g == 2'b10);
        e.busy  = |g;
        e.flag  = f;
        return e;
    endfunction

    function automatic exp_t obs();
        exp_t o;
        o = {grant, grant_id[0], bus_busy, timeout_flag};
        return o;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; release_pulse = '0; clear_err = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1; req = 2'b11; release_pulse = '0; clear_err = 1'b0;
        cyc();
        sb.push_back(mk(2'b00, 1'b0));
        cyc();
        e = sb.pop_front(); n_checks++;
        if (obs() !== e) $display("FAIL reset_state: got %b want %b", obs(), e);
        else n_pass++;
        reset = 1'b0; req = '0;
    endtask

    task automatic test_single();
        exp_t e;
        logic [1:0] exp_g [4] = '{2'b01, 2'b00, 2'b00, 2'b00};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req           = (i == 0) ? 2'b01 : 2'b00;
            release_pulse = (i == 1) ? 2'b01 : 2'b00;
            sb.push_back(mk(exp_g[i], 1'b0));
            cyc();
            e = sb.pop_front(); n_checks++;
            if (obs() !== e) $display("FAIL single step%0d: got %b want %b", i, obs(), e);
            else n_pass++;
        end
        release_pulse = '0;
    endtask

    task automatic test_alternate();
        exp_t e;
        logic [1:0] g;
        do_reset();
        req = 2'b11;
        for (int r = 0; r < 4; r++) begin
            g = (r % 2 == 0) ? 2'b01 : 2'b10;
            for (int s = 0; s < 5; s++) begin
                release_pulse = (s == 3) ? g : 2'b00;
                sb.push_back(mk((s < 3) ? g : 2'b00, 1'b0));
                cyc();
                e = sb.pop_front(); n_checks++;
                if (obs() !== e) $display("FAIL alternate r%0d s%0d: got %b want %b", r, s, obs(), e);
                else n_pass++;
            end
        end
        req = '0; release_pulse = '0;
    endtask

    task automatic test_timeout();
        exp_t e;
        do_reset();
        req = 2'b01;
        for (int i = 0; i < 11; i++) begin
            if (i == 9) req = 2'b11;
            if (i < 8)       sb.push_back(mk(2'b01, 1'b0));
            else if (i < 10) sb.push_back(mk(2'b00, 1'b1));
            else             sb.push_back(mk(2'b10, 1'b1));
            cyc();
            e = sb.pop_front(); n_checks++;
            if (obs() !== e) $display("FAIL timeout step%0d: got %b want %b", i, obs(), e);
            else n_pass++;
        end
        req = '0; release_pulse = 2'b10;
        cyc();
        release_pulse = '0;
        cyc();
    endtask

    task automatic test_release_on_timeout();
        exp_t e;
        do_reset();
        req = 2'b01;
        for (int i = 0; i < 10; i++) begin
            release_pulse = (i == 3) ? 2'b10 : (i == 8) ? 2'b01 : 2'b00;
            if (i == 9) req = 2'b00;
            sb.push_back(mk((i < 8) ? 2'b01 : 2'b00, 1'b0));
            cyc();
            e = sb.pop_front(); n_checks++;
            if (obs() !== e) $display("FAIL rel_on_timeout step%0d: got %b want %b", i, obs(), e);
            else n_pass++;
        end
        release_pulse = '0;
    endtask

    task automatic test_clear_err();
        exp_t e;
        do_reset();
        req = 2'b01;
        // steps 0-7 owned, 8 timeout drop, 9 idle, 10-17 owned, 18 timeout with clear
        for (int i = 0; i < 21; i++) begin
            clear_err = (i == 18 || i == 20);
            if (i == 19) req = 2'b00;
            if (i < 8)       sb.push_back(mk(2'b01, 1'b0));
            else if (i < 10) sb.push_back(mk(2'b00, 1'b1));
            else if (i < 18) sb.push_back(mk(2'b01, 1'b1));
            else if (i < 20) sb.push_back(mk(2'b00, 1'b1));
            else             sb.push_back(mk(2'b00, 1'b0));
            cyc();
            e = sb.pop_front(); n_checks++;
            if (obs() !== e) $display("FAIL clear_err step%0d: got %b want %b", i, obs(), e);
            else n_pass++;
        end
        clear_err = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [1:0] exp_g [7] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            req           = (i == 0) ? 2'b01 : (i < 4) ? 2'b10 : 2'b11;
            release_pulse = (i == 1) ? 2'b01 : 2'b00;
            reset         = (i == 5);
            sb.push_back(mk(exp_g[i], 1'b0));
            cyc();
            e = sb.pop_front(); n_checks++;
            if (obs() !== e) $display("FAIL reset_mid step%0d: got %b want %b", i, obs(), e);
            else n_pass++;
        end
        reset = 1'b0; req = '0; release_pulse = 2'b01;
        cyc();
        release_pulse = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req = '0; release_pulse = '0; clear_err = 1'b0;
        test_reset();
        test_single();
        test_alternate();
        test_timeout();
        test_release_on_timeout();
        test_clear_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
